// File: rtl/motor_cmd_uart_tx.sv
// Motor-command serial transmitter.
// Send requests (trigger rising edge, or a command change in auto mode) queue
// the current command in a small FIFO. Each entry is sent as a 3-byte 8N1
// frame: sync 0xA5, the command zero-extended to 8 bits, then 0xA5 ^ command.
// Frames waiting in the queue follow each other with no idle gap.
module motor_cmd_uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int CMD_WIDTH  = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int AUTO_SEND  = 0
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [CMD_WIDTH-1:0]          motor_cmd,
  input  logic                          trigger,
  output logic                          gpio,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  // Clock cycles per bit. Integer division truncates, so the real line rate
  // can be a little above BAUD.
  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [7:0]       SYNC_BYTE = 8'hA5;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // ---------------------------------------------------------------------
  // Request detection
  // ---------------------------------------------------------------------
  logic                 trig_q;
  logic [CMD_WIDTH-1:0] last_cmd;
  logic                 trig_rise;
  logic                 cmd_change;
  logic                 push_req;

  assign trig_rise  = trigger & ~trig_q;
  assign cmd_change = (AUTO_SEND != 0) && (motor_cmd != last_cmd);
  // A trigger edge coinciding with a command change is still a single push.
  assign push_req   = trig_rise | cmd_change;

  // Remember the previous trigger level and the last command that was queued.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      trig_q   <= 1'b0;
      last_cmd <= '0;
    end else begin
      trig_q <= trigger;
      if (push_req) begin
        last_cmd <= motor_cmd;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [CMD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     count_reg;
  logic [LVL_W-1:0]     count_next;
  logic                 overflow_reg;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 push_ok;
  logic [7:0]           head_byte;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == LVL_FULL);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // only dropped when nothing leaves that cycle.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign head_byte  = 8'(fifo_mem[rd_ptr]);

  // Occupancy after this edge; also feeds the registered busy flag.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + LVL_W'(1);
      2'b01:   count_next = count_reg - LVL_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Queue storage: written on accepted pushes only, no reset needed.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= motor_cmd;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_req && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------
  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [7:0]       tx_shift;
  logic [7:0]       cmd_byte;
  logic             gpio_reg;
  logic             busy_reg;
  logic             baud_done;
  logic             frame_end;
  logic             frame_active_next;

  assign baud_done = (baud_cnt == BAUD_LAST);
  // Last cycle of the stop bit of the checksum byte.
  assign frame_end = (state == STOP) && baud_done && (byte_idx == 2'd2);
  // An entry is taken either from idle or right at the end of a frame so
  // queued frames go out back-to-back.
  assign pop       = !fifo_empty && ((state == IDLE) || frame_end);
  assign frame_active_next = pop || ((state != IDLE) && !frame_end);

  // Frame FSM: one baud counter restarted on every bit, line driven from a register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx_shift <= '0;
      cmd_byte <= '0;
      gpio_reg <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          gpio_reg <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            cmd_byte <= head_byte;
            tx_shift <= SYNC_BYTE;
            byte_idx <= 2'd0;
            gpio_reg <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            gpio_reg <= tx_shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              gpio_reg <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              gpio_reg <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (byte_idx != 2'd2) begin
              byte_idx <= byte_idx + 2'd1;
              tx_shift <= (byte_idx == 2'd0) ? cmd_byte : (SYNC_BYTE ^ cmd_byte);
              gpio_reg <= 1'b0;
              state    <= START;
            end else if (pop) begin
              cmd_byte <= head_byte;
              tx_shift <= SYNC_BYTE;
              byte_idx <= 2'd0;
              gpio_reg <= 1'b0;
              state    <= START;
            end else begin
              gpio_reg <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          gpio_reg <= 1'b1;
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Busy is registered from next-cycle values so it follows the FSM and FIFO exactly.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      busy_reg <= 1'b0;
    end else begin
      busy_reg <= frame_active_next || (count_next != '0);
    end
  end

  assign gpio       = gpio_reg;
  assign busy       = busy_reg;
  assign overflow   = overflow_reg;
  assign fifo_level = count_reg;

endmodule
